// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - round-robin arbiter driving an encoded index + enable and a one-hot grant
//
// Purpose:
//   Shares one decoded resource (chip-select / write-enable fan-out) among
//   2**EncodeWidth requesters. One requester is granted and held until it
//   signals done or withdraws. A single dead cycle follows each grant so the
//   downstream decoder enable is low between owners. Priority then rotates
//   to the index after the last owner.
//
// Ports:
//   clk      in   1            clock, all state on rising edge
//   rst_n    in   1            asynchronous active-low reset, synchronous release
//   req      in   ReqCount     level request per requester
//   done     in   1            current grantee finished (sampled only while granted)
//   gnt_vld  out  1            grant active (decoder EN)
//   gnt_idx  out  EncodeWidth  encoded grantee (decoder IN), holds last value while idle
//   gnt      out  ReqCount     one-hot grant, zero when gnt_vld is low
//   timeout  out  1            one-cycle pulse when a grant was force-released
//
// Configuration:
//   HOLD_TIMEOUT_EN  when defined, a grant lasting MaxHold cycles without done
//                    or withdraw is force-released and timeout pulses during
//                    the following dead cycle. When undefined, grants are
//                    unbounded and timeout is tied low.

module rr_decode_arbiter #(
  parameter  int EncodeWidth = 4,
  localparam int ReqCount    = 2**EncodeWidth,
  parameter  int MaxHold     = 16,
  localparam int CntWidth    = $clog2(MaxHold + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ReqCount-1:0]    req,
  input  logic                   done,
  output logic                   gnt_vld,
  output logic [EncodeWidth-1:0] gnt_idx,
  output logic [ReqCount-1:0]    gnt,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [EncodeWidth-1:0] idx_q, idx_nxt;
  logic [EncodeWidth-1:0] last_q, last_nxt;
  logic [EncodeWidth-1:0] search_idx;
  logic [EncodeWidth-1:0] cand;
  logic                   limit_hit;
  logic                   release_now;

`ifdef HOLD_TIMEOUT_EN
  logic [CntWidth-1:0] cnt_q, cnt_nxt;
  logic                to_q, to_nxt;
`endif

  // Rotating search: offsets are walked from farthest to nearest so the
  // nearest requester above last_q wins. Offset ReqCount truncates to
  // last_q itself, letting a lone requester re-win after its release.
  always_comb begin
    search_idx = last_q;
    cand       = last_q;
    for (int i = ReqCount; i >= 1; i--) begin
      cand = last_q + EncodeWidth'(i);
      if (req[cand]) search_idx = cand;
    end
  end

`ifdef HOLD_TIMEOUT_EN
  // Counter reads 0 in the first granted cycle, so MaxHold-1 marks the last one.
  assign limit_hit = (cnt_q == CntWidth'(MaxHold - 1));
`else
  assign limit_hit = 1'b0;
`endif

  assign release_now = done | ~req[idx_q] | limit_hit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx_q  <= '0;
      last_q <= '1;
`ifdef HOLD_TIMEOUT_EN
      cnt_q  <= '0;
      to_q   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      idx_q  <= idx_nxt;
      last_q <= last_nxt;
`ifdef HOLD_TIMEOUT_EN
      cnt_q  <= cnt_nxt;
      to_q   <= to_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    last_nxt  = last_q;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          idx_nxt   = search_idx;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt = RELEASE;
          last_nxt  = idx_q;
        end
      end
      RELEASE: begin
        if (|req) begin
          state_nxt = GRANT;
          idx_nxt   = search_idx;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef HOLD_TIMEOUT_EN
  // Counter idles at zero, so it is already clear on every entry to GRANT.
  // A release caused by done or withdraw on the limit cycle is not a timeout.
  always_comb begin
    cnt_nxt = (state == GRANT) ? cnt_q + CntWidth'(1) : '0;
    to_nxt  = (state == GRANT) && limit_hit && !done && req[idx_q];
  end
`endif

  // Outputs decode registered state only; there is no input-to-output path.
  always_comb begin
    gnt_vld = (state == GRANT);
    gnt_idx = idx_q;
    gnt     = '0;
    if (state == GRANT) gnt[idx_q] = 1'b1;
`ifdef HOLD_TIMEOUT_EN
    timeout = to_q;
`else
    timeout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - scoreboard bench for rr_decode_arbiter
module tb_rr_decode_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic        gnt_vld;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit prev_vld = 1'b0;
  logic [3:0] prev_idx = '0;
  bit ok;
  int n;

  rr_decode_arbiter #(.EncodeWidth(4), .MaxHold(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .gnt     (gnt),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int cnt = 1);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grant(output bit got);
    int k;
    k = 0;
    while (!gnt_vld && k < 100) begin
      step(1);
      k++;
    end
    got = gnt_vld;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_grant: got no grant expected grant within 100 cycles");
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step(1);
    done = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Monitor: pops the expected index at each new grant and checks per-cycle invariants.
  always @(negedge clk) begin
    logic [15:0] exp_gnt;
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      exp_gnt = '0;
      if (gnt_vld) exp_gnt[gnt_idx] = 1'b1;
      chk("onehot", {16'h0, gnt}, {16'h0, exp_gnt});
      if (gnt_vld && prev_vld) chk("idx_stable", {28'h0, gnt_idx}, {28'h0, prev_idx});
      if (gnt_vld && !prev_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got idx %0d expected no grant", gnt_idx);
        end else begin
          chk("grant_idx", {28'h0, gnt_idx}, exp_q.pop_front());
        end
      end
`ifdef HOLD_TIMEOUT_EN
      if (timeout) chk("timeout_in_dead_cycle", {31'h0, gnt_vld}, 32'h0);
`else
      chk("timeout_tied_low", {31'h0, timeout}, 32'h0);
`endif
      prev_vld = gnt_vld;
      prev_idx = gnt_idx;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    // 1: reset state with all requesting
    rst_n = 1'b0;
    req   = 16'hFFFF;
    done  = 1'b0;
    step(2);
    chk("rst_gnt_vld", {31'h0, gnt_vld}, 32'h0);
    chk("rst_gnt", {16'h0, gnt}, 32'h0);
    chk("rst_timeout", {31'h0, timeout}, 32'h0);
    chk("rst_gnt_idx", {28'h0, gnt_idx}, 32'h0);
    exp_q.push_back(0);
    rst_n = 1'b1;
    step(1);
    chk("first_grant_vld", {31'h0, gnt_vld}, 32'h1);
    chk("first_grant_idx", {28'h0, gnt_idx}, 32'h0);
    req = 16'h0000;
    pulse_done();

    // 2: rotation over 0,4,8 with one dead cycle between grants
    reset_dut();
    req = 16'h0111;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(8);
    exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(8);
    for (int k = 0; k < 6; k++) begin
      wait_grant(ok);
      if (k == 5) req = 16'h0000;
      pulse_done();
      chk("gap_low", {31'h0, gnt_vld}, 32'h0);
      if (k < 5) begin
        step(1);
        chk("gap_one_cycle", {31'h0, gnt_vld}, 32'h1);
      end
    end
    step(1);

    // 3: move LAST to 14, then sparse request wraps to 1; then stay idle
    req = 16'h4000;
    exp_q.push_back(14);
    wait_grant(ok);
    req = 16'h0000;
    pulse_done();
    step(1);
    req = 16'h0002;
    exp_q.push_back(1);
    wait_grant(ok);
    chk("wrap_idx", {28'h0, gnt_idx}, 32'h1);
    req = 16'h0000;
    pulse_done();
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("idle_vld_low", {31'h0, gnt_vld}, 32'h0);
      chk("idle_idx_kept", {28'h0, gnt_idx}, 32'h1);
    end

    // 4: withdraw, no preemption, next owner after one dead cycle
    req = 16'h0008;
    exp_q.push_back(3);
    wait_grant(ok);
    req = 16'h000C;
    step(3);
    chk("no_preempt_idx", {28'h0, gnt_idx}, 32'h3);
    exp_q.push_back(5);
    req = 16'h0024;
    step(1);
    chk("withdraw_release", {31'h0, gnt_vld}, 32'h0);
    step(1);
    chk("after_withdraw_vld", {31'h0, gnt_vld}, 32'h1);
    chk("after_withdraw_idx", {28'h0, gnt_idx}, 32'h5);
    exp_q.push_back(2);
    req = 16'h0004;
    pulse_done();
    wait_grant(ok);
    req = 16'h0000;
    pulse_done();
    step(1);

    // 5: hold limit
    reset_dut();
    req = 16'h0003;
    exp_q.push_back(0);
`ifdef HOLD_TIMEOUT_EN
    exp_q.push_back(1);
`endif
    wait_grant(ok);
    n = 1;
    while (gnt_vld && n < 40) begin
      step(1);
      if (gnt_vld) n++;
    end
`ifdef HOLD_TIMEOUT_EN
    chk("hold_cycles", n, 16);
    chk("timeout_pulse", {31'h0, timeout}, 32'h1);
    step(1);
    chk("timeout_cleared", {31'h0, timeout}, 32'h0);
    chk("regrant_vld", {31'h0, gnt_vld}, 32'h1);
    chk("regrant_idx", {28'h0, gnt_idx}, 32'h1);
`else
    chk("hold_unbounded", n, 40);
    chk("timeout_zero", {31'h0, timeout}, 32'h0);
`endif
    req = 16'h0000;
    pulse_done();
    step(1);

    // 6: async reset mid-grant, then re-grant after release
    req = 16'h0080;
    exp_q.push_back(7);
    wait_grant(ok);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", {31'h0, gnt_vld}, 32'h0);
    chk("async_rst_gnt", {16'h0, gnt}, 32'h0);
    step(1);
    exp_q.push_back(7);
    rst_n = 1'b1;
    wait_grant(ok);
    chk("post_rst_idx", {28'h0, gnt_idx}, 32'h7);
    req = 16'h0000;
    pulse_done();
    step(3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
